// File: rtl/tage_pkg.sv
// rtl/tage_pkg.sv - shared types and helpers for the TAGE update scheduler
package tage_pkg;

   localparam int TAGE_NUM_TABLES = 4;
   localparam int TAGE_PC_W       = 32;
   localparam int TAGE_TBL_W      = $clog2(TAGE_NUM_TABLES + 1);

   typedef enum logic [2:0] {
      OP_CTR_INC  = 3'd0,
      OP_CTR_DEC  = 3'd1,
      OP_U_INC    = 3'd2,
      OP_U_DEC    = 3'd3,
      OP_ALLOC_T  = 3'd4,
      OP_ALLOC_NT = 3'd5
   } tage_op_e;

   typedef struct packed {
      logic [TAGE_PC_W-1:0]       pc;
      logic                       taken;
      logic                       mispred;
      logic [TAGE_TBL_W-1:0]      prov;
      logic                       alt_diff;
      logic [TAGE_NUM_TABLES-1:0] alloc_mask;
   } upd_req_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CTR   = 3'd1,
      S_USE   = 3'd2,
      S_ALLOC = 3'd3,
      S_DECAY = 3'd4
   } sched_state_e;

   // Returns {found, table}: the lowest table above prov whose entry has u==0.
   function automatic logic [TAGE_TBL_W:0] pick_alloc(
      input logic [TAGE_NUM_TABLES-1:0] mask,
      input logic [TAGE_TBL_W-1:0]      prov
   );
      pick_alloc = '0;
      for (int k = TAGE_NUM_TABLES; k >= 1; k--) begin
         if (mask[k-1] && (TAGE_TBL_W'(k) > prov)) begin
            pick_alloc = {1'b1, TAGE_TBL_W'(k)};
         end
      end
   endfunction

endpackage

// File: rtl/tage_upd_sched_if.sv
// rtl/tage_upd_sched_if.sv - update-request, write-command and status signals of the scheduler
interface tage_upd_sched_if
   import tage_pkg::*;
#(
   parameter int NUM_TABLES = TAGE_NUM_TABLES,
   parameter int PC_W       = TAGE_PC_W
);
   localparam int TBL_W = $clog2(NUM_TABLES + 1);

   logic                  i_upd_vld;
   logic                  o_upd_rdy;
   logic [PC_W-1:0]       i_upd_pc;
   logic                  i_upd_taken;
   logic                  i_upd_mispred;
   logic [TBL_W-1:0]      i_upd_prov;
   logic                  i_upd_alt_diff;
   logic [NUM_TABLES-1:0] i_upd_alloc_mask;

   logic                  o_cmd_vld;
   logic                  i_cmd_rdy;
   logic [TBL_W-1:0]      o_cmd_tbl;
   tage_op_e              o_cmd_op;
   logic [PC_W-1:0]       o_cmd_pc;

   logic                  o_busy;
   logic [15:0]           o_decay_cnt;

   modport slave (
      input  i_upd_vld, i_upd_pc, i_upd_taken, i_upd_mispred, i_upd_prov,
             i_upd_alt_diff, i_upd_alloc_mask, i_cmd_rdy,
      output o_upd_rdy, o_cmd_vld, o_cmd_tbl, o_cmd_op, o_cmd_pc, o_busy, o_decay_cnt
   );

   modport master (
      output i_upd_vld, i_upd_pc, i_upd_taken, i_upd_mispred, i_upd_prov,
             i_upd_alt_diff, i_upd_alloc_mask, i_cmd_rdy,
      input  o_upd_rdy, o_cmd_vld, o_cmd_tbl, o_cmd_op, o_cmd_pc, o_busy, o_decay_cnt
   );

endinterface

// File: rtl/tage_upd_fifo.sv
// rtl/tage_upd_fifo.sv - generic valid/ready FIFO, power-of-two depth
module tage_upd_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_wr_vld,
   output logic         o_wr_rdy,
   input  logic [W-1:0] i_wr_data,
   output logic         o_rd_vld,
   input  logic         i_rd_rdy,
   output logic [W-1:0] o_rd_data
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, rd_ptr_q;
   logic         full, empty, push, pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign push  = i_wr_vld && !full;
   assign pop   = i_rd_rdy && !empty;

   assign o_wr_rdy  = !full;
   assign o_rd_vld  = !empty;
   assign o_rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
   end

endmodule

// File: rtl/tage_upd_sched.sv
// rtl/tage_upd_sched.sv - TAGE update scheduler: request FIFO plus single-port write sequencer
module tage_upd_sched
   import tage_pkg::*;
#(
   parameter int NUM_TABLES = TAGE_NUM_TABLES,
   parameter int FIFO_DEPTH = 4,
   parameter int PC_W       = TAGE_PC_W
) (
   input  logic            i_clk,
   input  logic            i_reset,
   tage_upd_sched_if.slave bus
);
   localparam int               TBL_W    = $clog2(NUM_TABLES + 1);
   localparam logic [TBL_W-1:0] LAST_TBL = TBL_W'(NUM_TABLES);

   sched_state_e     state_q;
   upd_req_t         in_req, head_req, wk_q;
   logic             fifo_vld, fifo_pop, fifo_wr_rdy;
   logic             cmd_vld_q;
   logic [TBL_W-1:0] cmd_tbl_q, cursor_q, next_tbl;
   tage_op_e         cmd_op_q, alloc_op;
   logic [TBL_W:0]   pick;
   logic             accept, use_needed, alloc_needed;
   logic [15:0]      decay_cnt_q;

   // Illegal provider ids are folded to the bimodal table on entry.
   always_comb begin
      in_req            = '0;
      in_req.pc         = bus.i_upd_pc;
      in_req.taken      = bus.i_upd_taken;
      in_req.mispred    = bus.i_upd_mispred;
      in_req.prov       = (bus.i_upd_prov > LAST_TBL) ? '0 : bus.i_upd_prov;
      in_req.alt_diff   = bus.i_upd_alt_diff;
      in_req.alloc_mask = bus.i_upd_alloc_mask;
   end

   assign fifo_pop = (state_q == S_IDLE);

   tage_upd_fifo #(
      .W     ($bits(upd_req_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_wr_vld  (bus.i_upd_vld),
      .o_wr_rdy  (fifo_wr_rdy),
      .i_wr_data (in_req),
      .o_rd_vld  (fifo_vld),
      .i_rd_rdy  (fifo_pop),
      .o_rd_data (head_req)
   );

   assign accept       = cmd_vld_q && bus.i_cmd_rdy;
   assign use_needed   = (wk_q.prov != '0) && wk_q.alt_diff;
   assign alloc_needed = wk_q.mispred && (wk_q.prov < LAST_TBL);
   assign pick         = pick_alloc(wk_q.alloc_mask, wk_q.prov);
   assign next_tbl     = wk_q.prov + 1'b1;
   assign alloc_op     = wk_q.taken ? OP_ALLOC_T : OP_ALLOC_NT;

   // Each state arms the next command on the accepting edge so a sequence runs without bubbles.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= S_IDLE;
         wk_q        <= '0;
         cursor_q    <= '0;
         cmd_vld_q   <= 1'b0;
         cmd_tbl_q   <= '0;
         cmd_op_q    <= OP_CTR_INC;
         decay_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fifo_vld) begin
                  wk_q      <= head_req;
                  state_q   <= S_CTR;
                  cmd_vld_q <= 1'b1;
                  cmd_tbl_q <= head_req.prov;
                  cmd_op_q  <= head_req.taken ? OP_CTR_INC : OP_CTR_DEC;
               end
            end
            S_CTR: begin
               if (accept) begin
                  if (use_needed) begin
                     state_q  <= S_USE;
                     cmd_op_q <= wk_q.mispred ? OP_U_DEC : OP_U_INC;
                  end else if (alloc_needed) begin
                     state_q   <= S_ALLOC;
                     cmd_vld_q <= pick[TBL_W];
                     cmd_tbl_q <= pick[TBL_W-1:0];
                     cmd_op_q  <= alloc_op;
                  end else begin
                     state_q   <= S_IDLE;
                     cmd_vld_q <= 1'b0;
                  end
               end
            end
            S_USE: begin
               if (accept) begin
                  if (alloc_needed) begin
                     state_q   <= S_ALLOC;
                     cmd_vld_q <= pick[TBL_W];
                     cmd_tbl_q <= pick[TBL_W-1:0];
                     cmd_op_q  <= alloc_op;
                  end else begin
                     state_q   <= S_IDLE;
                     cmd_vld_q <= 1'b0;
                  end
               end
            end
            S_ALLOC: begin
               // No free entry above the provider: age every higher table instead.
               if (!pick[TBL_W]) begin
                  state_q   <= S_DECAY;
                  cursor_q  <= next_tbl;
                  cmd_vld_q <= 1'b1;
                  cmd_tbl_q <= next_tbl;
                  cmd_op_q  <= OP_U_DEC;
                  if (decay_cnt_q != 16'hFFFF) decay_cnt_q <= decay_cnt_q + 16'd1;
               end else if (accept) begin
                  state_q   <= S_IDLE;
                  cmd_vld_q <= 1'b0;
               end
            end
            S_DECAY: begin
               if (accept) begin
                  if (cursor_q == LAST_TBL) begin
                     state_q   <= S_IDLE;
                     cmd_vld_q <= 1'b0;
                  end else begin
                     cursor_q  <= cursor_q + 1'b1;
                     cmd_tbl_q <= cursor_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= S_IDLE;
               cmd_vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_upd_rdy   = fifo_wr_rdy;
   assign bus.o_cmd_vld   = cmd_vld_q;
   assign bus.o_cmd_tbl   = cmd_tbl_q;
   assign bus.o_cmd_op    = cmd_op_q;
   assign bus.o_cmd_pc    = PC_W'(wk_q.pc);
   assign bus.o_busy      = (state_q != S_IDLE) || fifo_vld;
   assign bus.o_decay_cnt = decay_cnt_q;

   a_prov_legal: assert property (@(posedge i_clk) disable iff (!i_reset)
      (bus.i_upd_vld && bus.o_upd_rdy) |-> (bus.i_upd_prov <= LAST_TBL));

endmodule

// File: tb/tb_tage_upd_sched.sv
// tb/tb_tage_upd_sched.sv - self-checking bench for tage_upd_sched
module tb_tage_upd_sched;
   import tage_pkg::*;

   localparam int NT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   decay_exp = 0;

   logic [37:0] exp_q[$];
   logic [37:0] obs_q[$];
   int          obs_cyc_q[$];

   tage_upd_sched_if #(.NUM_TABLES(NT), .PC_W(32)) upd();

   tage_upd_sched #(.NUM_TABLES(NT), .FIFO_DEPTH(4), .PC_W(32)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (upd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n && upd.o_cmd_vld && upd.i_cmd_rdy) begin
         obs_q.push_back({upd.o_cmd_tbl, 3'(upd.o_cmd_op), upd.o_cmd_pc});
         obs_cyc_q.push_back(cyc);
      end
   end

   function automatic logic [37:0] cmd_word(input int t, input tage_op_e op, input logic [31:0] pc);
      return {3'(t), 3'(op), pc};
   endfunction

   // Reference: expand one request into the list of table writes it must cause.
   task automatic model_push(input logic [31:0] pc, input bit taken, input bit mispred,
                             input bit alt, input int prov, input logic [3:0] mask);
      int p;
      int tgt;
      p   = (prov > NT) ? 0 : prov;
      tgt = 0;
      exp_q.push_back(cmd_word(p, taken ? OP_CTR_INC : OP_CTR_DEC, pc));
      if (p != 0 && alt) exp_q.push_back(cmd_word(p, mispred ? OP_U_DEC : OP_U_INC, pc));
      if (mispred && p < NT) begin
         for (int k = NT; k > p; k--) if (mask[k-1]) tgt = k;
         if (tgt != 0) exp_q.push_back(cmd_word(tgt, taken ? OP_ALLOC_T : OP_ALLOC_NT, pc));
         else begin
            decay_exp++;
            for (int k = p + 1; k <= NT; k++) exp_q.push_back(cmd_word(k, OP_U_DEC, pc));
         end
      end
   endtask

   task automatic push_req(input logic [31:0] pc, input bit taken, input bit mispred,
                           input bit alt, input int prov, input logic [3:0] mask);
      bit r;
      r = 1'b0;
      upd.i_upd_vld = 1'b1; upd.i_upd_pc = pc; upd.i_upd_taken = taken;
      upd.i_upd_mispred = mispred; upd.i_upd_alt_diff = alt;
      upd.i_upd_prov = 3'(prov); upd.i_upd_alloc_mask = mask;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk); r = upd.o_upd_rdy;
         @(posedge clk); #1;
         if (r) break;
      end
      upd.i_upd_vld = 1'b0;
      if (r) model_push(pc, taken, mispred, alt, prov, mask);
      else begin checks++; errors++; $display("FAIL push_timeout: got rdy=0 required rdy=1 within 100 cycles"); end
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (!upd.o_busy) begin idle = 1'b1; break; end
      end
      @(posedge clk); #1;
      if (!idle) begin checks++; errors++; $display("FAIL idle_timeout: got busy=1 required busy=0 within 500 cycles"); end
   endtask

   task automatic clear_q();
      exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
   endtask

   task automatic test_reset();
      upd.i_upd_vld = 0; upd.i_upd_pc = 0; upd.i_upd_taken = 0; upd.i_upd_mispred = 0;
      upd.i_upd_prov = 0; upd.i_upd_alt_diff = 0; upd.i_upd_alloc_mask = 0; upd.i_cmd_rdy = 1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (upd.o_cmd_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b required 0", upd.o_cmd_vld); end
      checks++; if (upd.o_cmd_tbl !== 3'd0) begin errors++; $display("FAIL rst_tbl: got %0d required 0", upd.o_cmd_tbl); end
      checks++; if (upd.o_cmd_op !== OP_CTR_INC) begin errors++; $display("FAIL rst_op: got %0d required %0d", upd.o_cmd_op, OP_CTR_INC); end
      checks++; if (upd.o_cmd_pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h required 0", upd.o_cmd_pc); end
      checks++; if (upd.o_upd_rdy !== 1'b1) begin errors++; $display("FAIL rst_upd_rdy: got %b required 1", upd.o_upd_rdy); end
      checks++; if (upd.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", upd.o_busy); end
      checks++; if (upd.o_decay_cnt !== 16'd0) begin errors++; $display("FAIL rst_decay: got %0d required 0", upd.o_decay_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [31:0] pc;
      logic [37:0] cur;
      pc = $urandom;
      push_req(pc, 1'b1, 1'b0, 1'($urandom), 0, 4'($urandom));
      @(negedge clk);
      checks++; if (upd.o_cmd_vld !== 1'b0) begin errors++; $display("FAIL single_prepop_vld: got %b required 0", upd.o_cmd_vld); end
      checks++; if (upd.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy_queued: got %b required 1", upd.o_busy); end
      @(negedge clk);
      cur = {upd.o_cmd_tbl, 3'(upd.o_cmd_op), upd.o_cmd_pc};
      checks++; if (upd.o_cmd_vld !== 1'b1) begin errors++; $display("FAIL single_first_vld: got %b required 1", upd.o_cmd_vld); end
      checks++; if (cur !== exp_q[0]) begin errors++; $display("FAIL single_cmd: got %h required %h", cur, exp_q[0]); end
      @(negedge clk);
      checks++; if (upd.o_cmd_vld !== 1'b0) begin errors++; $display("FAIL single_post_vld: got %b required 0", upd.o_cmd_vld); end
      checks++; if (upd.o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b required 0", upd.o_busy); end
      checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d required 1", obs_q.size()); end
      @(posedge clk); #1;
      clear_q();
   endtask

   task automatic test_use_alloc();
      push_req($urandom, 1'b0, 1'b1, 1'b1, 2, 4'b1010);
      wait_idle();
      checks++; if (obs_q.size() !== 3 || exp_q.size() !== 3) begin errors++; $display("FAIL ua_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ua_cmd%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
      end
      if (obs_cyc_q.size() == 3) begin
         checks++; if (obs_cyc_q[2] - obs_cyc_q[0] !== 2) begin errors++; $display("FAIL ua_b2b: got span %0d required 2", obs_cyc_q[2] - obs_cyc_q[0]); end
      end
      clear_q();
   endtask

   task automatic test_decay();
      push_req($urandom, 1'b1, 1'b1, 1'b0, 1, 4'b0001);
      wait_idle();
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL decay_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL decay_cmd%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (upd.o_decay_cnt !== 16'(decay_exp)) begin errors++; $display("FAIL decay_cnt: got %0d required %0d", upd.o_decay_cnt, decay_exp); end
      clear_q();
   endtask

   task automatic test_top_prov();
      push_req($urandom, 1'($urandom), 1'b1, 1'b1, 4, 4'b1111);
      wait_idle();
      checks++; if (obs_q.size() !== 2 || exp_q.size() !== 2) begin errors++; $display("FAIL top_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL top_cmd%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
      end
      clear_q();
   endtask

   task automatic test_stall();
      logic [31:0] pcs[6];
      bit tk[6], mp[6], ad[6];
      int pv[6];
      logic [3:0] msk[6];
      logic [37:0] cur, first;
      int idx, acc20;
      bit r, have_first, held_bad, rdy_bad;
      idx = 0; acc20 = 0; have_first = 0; held_bad = 0; rdy_bad = 0; first = '0;
      for (int i = 0; i < 6; i++) begin
         pcs[i] = $urandom; tk[i] = 1'($urandom); mp[i] = 1'($urandom); ad[i] = 1'($urandom);
         pv[i] = $urandom_range(0, NT); msk[i] = 4'($urandom);
      end
      upd.i_cmd_rdy = 1'b0;
      for (int c = 0; c < 300 && idx < 6; c++) begin
         upd.i_upd_vld = 1'b1; upd.i_upd_pc = pcs[idx]; upd.i_upd_taken = tk[idx];
         upd.i_upd_mispred = mp[idx]; upd.i_upd_alt_diff = ad[idx];
         upd.i_upd_prov = 3'(pv[idx]); upd.i_upd_alloc_mask = msk[idx];
         @(negedge clk);
         r = upd.o_upd_rdy;
         cur = {upd.o_cmd_tbl, 3'(upd.o_cmd_op), upd.o_cmd_pc};
         if (c < 20) begin
            if (have_first && (!upd.o_cmd_vld || cur !== first)) held_bad = 1'b1;
            if (!have_first && upd.o_cmd_vld) begin first = cur; have_first = 1'b1; end
            if (c >= 5 && r) rdy_bad = 1'b1;
         end
         @(posedge clk); #1;
         if (r) begin model_push(pcs[idx], tk[idx], mp[idx], ad[idx], pv[idx], msk[idx]); idx++; end
         if (c == 19) begin acc20 = idx; upd.i_cmd_rdy = 1'b1; end
      end
      upd.i_upd_vld = 1'b0;
      checks++; if (acc20 !== 5) begin errors++; $display("FAIL stall_accepted: got %0d required 5", acc20); end
      checks++; if (rdy_bad) begin errors++; $display("FAIL stall_upd_rdy: got 1 required 0 while full"); end
      checks++; if (held_bad) begin errors++; $display("FAIL stall_hold: got changing command required stable"); end
      checks++; if (first !== exp_q[0]) begin errors++; $display("FAIL stall_first: got %h required %h", first, exp_q[0]); end
      checks++; if (idx !== 6) begin errors++; $display("FAIL stall_sixth: got %0d pushes required 6", idx); end
      wait_idle();
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_cmd%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
      end
      clear_q();
   endtask

   task automatic test_random();
      logic [31:0] pc;
      bit tk, mp, ad, r, idle;
      int pv, sent;
      logic [3:0] msk;
      sent = 0; idle = 0; pc = '0; tk = 0; mp = 0; ad = 0; pv = 0; msk = '0;
      for (int c = 0; c < 3000 && sent < 25; c++) begin
         upd.i_cmd_rdy = ($urandom_range(0, 3) != 0);
         if (!upd.i_upd_vld && $urandom_range(0, 1) == 1) begin
            pc = $urandom; tk = 1'($urandom); mp = 1'($urandom); ad = 1'($urandom);
            pv = $urandom_range(0, NT); msk = 4'($urandom);
            upd.i_upd_pc = pc; upd.i_upd_taken = tk; upd.i_upd_mispred = mp;
            upd.i_upd_alt_diff = ad; upd.i_upd_prov = 3'(pv); upd.i_upd_alloc_mask = msk;
            upd.i_upd_vld = 1'b1;
         end
         @(negedge clk); r = upd.o_upd_rdy && upd.i_upd_vld;
         @(posedge clk); #1;
         if (r) begin model_push(pc, tk, mp, ad, pv, msk); sent++; upd.i_upd_vld = 1'b0; end
      end
      upd.i_upd_vld = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         upd.i_cmd_rdy = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (!upd.o_busy) begin idle = 1'b1; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      upd.i_cmd_rdy = 1'b1;
      checks++; if (!idle || sent !== 25) begin errors++; $display("FAIL rand_drain: got idle=%0d sent=%0d required 1/25", idle, sent); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_cmd%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (upd.o_decay_cnt !== 16'(decay_exp)) begin errors++; $display("FAIL rand_decay_cnt: got %0d required %0d", upd.o_decay_cnt, decay_exp); end
      clear_q();
   endtask

   task automatic test_reset_mid();
      bit seen, bad_vld, bad_busy;
      seen = 0; bad_vld = 0; bad_busy = 0;
      upd.i_cmd_rdy = 1'b1;
      push_req($urandom, 1'b1, 1'b1, 1'b0, 1, 4'b0000);
      push_req($urandom, 1'b0, 1'b0, 1'b0, 3, 4'b0000);
      push_req($urandom, 1'b1, 1'b1, 1'b1, 2, 4'b1000);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (upd.o_cmd_vld && upd.o_cmd_op == OP_U_DEC) begin seen = 1'b1; break; end
      end
      checks++; if (!seen) begin errors++; $display("FAIL mid_reach_decay: got no decay command required one within 20 cycles"); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (upd.o_cmd_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %b required 0", upd.o_cmd_vld); end
      checks++; if (upd.o_cmd_tbl !== 3'd0 || upd.o_cmd_op !== OP_CTR_INC) begin errors++; $display("FAIL mid_cmd: got tbl=%0d op=%0d required 0/0", upd.o_cmd_tbl, upd.o_cmd_op); end
      checks++; if (upd.o_cmd_pc !== 32'd0) begin errors++; $display("FAIL mid_pc: got %h required 0", upd.o_cmd_pc); end
      checks++; if (upd.o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", upd.o_busy); end
      checks++; if (upd.o_decay_cnt !== 16'd0) begin errors++; $display("FAIL mid_decay: got %0d required 0", upd.o_decay_cnt); end
      clear_q();
      decay_exp = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (upd.o_cmd_vld) bad_vld = 1'b1;
         if (upd.o_busy) bad_busy = 1'b1;
      end
      checks++; if (bad_vld) begin errors++; $display("FAIL mid_post_vld: got 1 required 0"); end
      checks++; if (bad_busy) begin errors++; $display("FAIL mid_post_busy: got 1 required 0"); end
      checks++; if (upd.o_upd_rdy !== 1'b1) begin errors++; $display("FAIL mid_upd_rdy: got %b required 1", upd.o_upd_rdy); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion required finish before 500000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_use_alloc();
      test_decay();
      test_top_prov();
      test_stall();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tage_upd_sched.md
Name: tage_upd_sched

Overview:
Update scheduler for the tagged-geometric (TAGE) branch predictor in the pipelined core. It buffers resolved-branch update requests from EX in a small FIFO. It then sequences each request into a series of single-table write commands (counter, useful bit, allocation, useful decay) onto the predictor's one shared write port. The predictor's lookup path has priority over this port and stalls the scheduler through i_cmd_rdy.

Parameters:
NUM_TABLES, 4, number of tagged tables; tables are numbered 1..NUM_TABLES, and table 0 is the bimodal base
FIFO_DEPTH, 4, update FIFO entries (power of 2, >=2)
PC_W, 32, PC width
TBL_W, $clog2(NUM_TABLES+1), table-id width (derived)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-low reset
i_upd_vld  in  1  update request valid
o_upd_rdy  out  1  FIFO can accept; a transfer happens when vld&&rdy
i_upd_pc  in  PC_W  branch PC
i_upd_taken  in  1  resolved direction
i_upd_mispred  in  1  final prediction was wrong
i_upd_prov  in  TBL_W  provider table (0 = bimodal)
i_upd_alt_diff  in  1  provider prediction differed from the alternate prediction
i_upd_alloc_mask  in  NUM_TABLES  bit k-1 set means table k has u==0 at the indexed entry
o_cmd_vld  out  1  write command valid
i_cmd_rdy  in  1  predictor accepts the command
o_cmd_tbl  out  TBL_W  target table
o_cmd_op  out  3  tage_op_e
o_cmd_pc  out  PC_W  PC; the table re-derives index and tag from it
o_busy  out  1  FSM not in S_IDLE, or FIFO non-empty
o_decay_cnt  out  16  saturating count of decay sequences

Behaviour:
- Reset (asynchronous, active-low):
  - FIFO emptied; FSM to S_IDLE; working register cleared.
  - o_cmd_vld=0, o_cmd_tbl=0, o_cmd_op=OP_CTR_INC, o_cmd_pc=0.
  - o_upd_rdy=1 after reset release; o_busy=0; o_decay_cnt=0.
  - Asserting reset mid-sequence discards all queued and in-flight work. No partial command is held.
- FIFO:
  - o_upd_rdy = !full, decoded from registered state only.
  - A push while full is impossible, even on a simultaneous pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - Ordering is strict FIFO.
- Working register: loaded from the FIFO head in S_IDLE when the FIFO is non-empty. Popping frees a slot, so FIFO_DEPTH+1 requests can be held in total.
- Commands:
  - All command outputs are registered.
  - While o_cmd_vld && !i_cmd_rdy, o_cmd_tbl, o_cmd_op and o_cmd_pc hold stable.
  - Acceptance happens on a rising edge with vld&&rdy. The next command of the same sequence is valid in the following cycle, with no bubble.
- FSM:
  - S_IDLE: if FIFO non-empty, pop into the working register and go to S_CTR. o_cmd_vld is asserted from the cycle after the pop.
  - S_CTR: issue (prov, taken ? OP_CTR_INC : OP_CTR_DEC). On accept:
    - go to S_USE if prov!=0 && alt_diff;
    - else go to S_ALLOC if mispred && prov<NUM_TABLES;
    - else go to S_IDLE.
  - S_USE: issue (prov, mispred ? OP_U_DEC : OP_U_INC). On accept, go to S_ALLOC if mispred && prov<NUM_TABLES, else S_IDLE.
  - S_ALLOC: cand = alloc_mask & tables strictly greater than prov.
    - If cand != 0: issue (lowest table in cand, taken ? OP_ALLOC_T : OP_ALLOC_NT). On accept, go to S_IDLE.
    - If cand == 0: set cursor = prov+1, increment o_decay_cnt (saturating at 16'hFFFF), and go to S_DECAY with no command this cycle.
  - S_DECAY: issue (cursor, OP_U_DEC). On accept, cursor++. Go to S_IDLE after accepting cursor==NUM_TABLES.
- Latency with an empty FIFO and i_cmd_rdy=1: request accepted at edge t, popped at edge t+1, first command accepted at edge t+2.
- i_upd_prov > NUM_TABLES is illegal. An SVA assertion flags it, and such a request is treated as prov=0.

Decomposition:
- Package tage_pkg:
  - tage_op_e = {OP_CTR_INC, OP_CTR_DEC, OP_U_INC, OP_U_DEC, OP_ALLOC_T, OP_ALLOC_NT};
  - struct upd_req_t {pc, taken, mispred, prov, alt_diff, alloc_mask};
  - sched_state_e.
- One sub-module, tage_upd_fifo: generic valid/ready FIFO parameterized on width and depth, storing upd_req_t.

Test Plan:
All scenarios use NUM_TABLES=4 and i_cmd_rdy=1 unless stated otherwise.
1. prov=0, taken=1, mispred=0 -> exactly one command (0, OP_CTR_INC, pc); o_busy falls 1 cycle after accept.
2. prov=2, taken=0, mispred=1, alt_diff=1, mask=4'b1010 -> commands (2,CTR_DEC), (2,U_DEC), (4,ALLOC_NT) on consecutive cycles.
3. prov=1, taken=1, mispred=1, alt_diff=0, mask=4'b0001 -> (1,CTR_INC), (2,U_DEC), (3,U_DEC), (4,U_DEC); o_decay_cnt=1.
4. prov=4, mispred=1, alt_diff=1 -> (4,CTR_*), (4,U_DEC) only; no allocation.
5. i_cmd_rdy=0 for 20 cycles with 6 back-to-back pushes -> first command held stable; 5 pushes accepted (1 working + 4 FIFO); o_upd_rdy=0 on the 6th until the first pop after rdy returns; all commands emerge in order.
6. Assert i_reset during S_DECAY with 2 entries queued -> all outputs at reset values immediately; after release, o_cmd_vld stays 0 and o_busy=0.
